uart_rx_fifo: RTL

- Memory-mappable UART receiver that sits directly upstream of the SOC core's UART data register and consumes the SOC's RXD pin.
- Samples the asynchronous 8N1 serial line, assembles bytes and buffers them in a first-word-fall-through (FWFT) FIFO.
- The CPU polls rx_valid and pops bytes through the SOC bus decode.
- Error conditions are reported through sticky status flags.

---
 rtl/uart_rx_fifo.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1) feeding a first-word-fall-through byte FIFO with sticky error flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err.
//   state  | meaning
//   IDLE   | line idle, waiting for a falling edge on rxs
//   START  | half-bit wait, then confirm the start bit is still low
//   DATA   | sample 8 data bits LSB first, one per bit period
//   PARITY | sample the even-parity bit (parity build only)
//   STOP   | sample the stop bit; push the byte or flag a framing error
//   BREAK  | line held low after a bad stop bit, wait for it to go high
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        RXD,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_pop,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        frame_err,
  output logic                        overrun,
  output logic                        parity_err,
  input  logic                        err_clr
);
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t        state, state_nx;
  logic          rx_meta, rxs;
  logic [TW-1:0] tmr, tmr_val;
  logic          tmr_ld;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          bit_clr, shift, push, set_ferr;
`ifdef UART_RX_PARITY_EN
  logic          set_perr;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) {rxs, rx_meta} <= 2'b11;
    else       {rxs, rx_meta} <= {rx_meta, RXD};
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tmr_ld   = 1'b0;
    tmr_val  = '0;
    bit_clr  = 1'b0;
    shift    = 1'b0;
    push     = 1'b0;
    set_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
    set_perr = 1'b0;
`endif
    case (state)
      S_IDLE: if (!rxs) begin
        state_nx = S_START;
        tmr_ld   = 1'b1;
        tmr_val  = T_HALF;
        bit_clr  = 1'b1;
      end
      S_START: if (tmr == '0) begin
        if (rxs) state_nx = S_IDLE;
        else begin
          state_nx = S_DATA;
          tmr_ld   = 1'b1;
          tmr_val  = T_FULL;
        end
      end
      S_DATA: if (tmr == '0) begin
        shift   = 1'b1;
        tmr_ld  = 1'b1;
        tmr_val = T_FULL;
`ifdef UART_RX_PARITY_EN
        if (bitcnt == 3'd7) state_nx = S_PARITY;
`else
        if (bitcnt == 3'd7) state_nx = S_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (tmr == '0) begin
        set_perr = ^{shreg, rxs};
        tmr_ld   = 1'b1;
        tmr_val  = T_FULL;
        state_nx = S_STOP;
      end
`endif
      S_STOP: if (tmr == '0) begin
        if (rxs) begin
          push     = 1'b1;
          state_nx = S_IDLE;
        end else begin
          set_ferr = 1'b1;
          state_nx = S_BREAK;
        end
      end
      S_BREAK: if (rxs) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Bit timer counts down to zero; each state reloads it for the next sample point.
  always_ff @(posedge CLK) begin
    if (RESET)            tmr <= '0;
    else if (tmr_ld)      tmr <= tmr_val;
    else if (tmr != '0)   tmr <= tmr - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      if (bit_clr)    bitcnt <= '0;
      else if (shift) bitcnt <= bitcnt + 1'b1;
      if (shift)      shreg  <= {rxs, shreg[7:1]};
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_pop, do_push;

  assign rx_valid = (rx_count != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;
  assign do_pop   = rx_pop && rx_valid;
  // A full FIFO still accepts the byte if the head is popped in the same cycle.
  assign do_push  = push && !RESET && ((rx_count != DEPTH) || do_pop);

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (set_ferr)            frame_err <= 1'b1;
      else if (err_clr)        frame_err <= 1'b0;
      if (push && !do_push)    overrun   <= 1'b1;
      else if (err_clr)        overrun   <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK) begin
    if (RESET)         parity_err <= 1'b0;
    else if (set_perr) parity_err <= 1'b1;
    else if (err_clr)  parity_err <= 1'b0;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
